// File: rtl/rv32_pkg.sv
// Shared constants and encodings for the regfile writeback arbiter.
// Provides XLEN/AW, the arbiter FSM states and the grant identifiers.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] CLR_FIRST = AW'(1);
    localparam logic [AW-1:0] CLR_LAST  = AW'(31);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready requesters, clear control, regfile port.
// master = requester/regfile side, slave = the arbiter.
interface regfile_wb_arbiter_if;
    import rv32_pkg::*;

    logic            clr_req;
    logic            clr_busy;
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_wd;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_wd;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [15:0]     stall_cnt;

    modport master (
        output clr_req, a_valid, a_rd, a_wd,
        output b_valid, b_rd, b_wd,
        input  clr_busy, a_ready, b_ready,
        input  rf_we, rf_rd, rf_wd, stall_cnt
    );

    modport slave (
        input  clr_req, a_valid, a_rd, a_wd,
        input  b_valid, b_rd, b_wd,
        output clr_busy, a_ready, b_ready,
        output rf_we, rf_rd, rf_wd, stall_cnt
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: valids + last grant -> one-hot grant.
// Ports: en_i, a_valid_i, b_valid_i, last_i in; gnt_o[0]=A, gnt_o[1]=B.
module rr_arb2
    import rv32_pkg::*;
(
    input  logic       en_i,
    input  logic       a_valid_i,
    input  logic       b_valid_i,
    input  gnt_e       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            // On a tie the side that did not win last time goes first.
            if (a_valid_i && (!b_valid_i || last_i == GNT_B)) begin
                gnt_o[0] = 1'b1;
            end else if (b_valid_i) begin
                gnt_o[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the regfile write port: round-robin A/B writeback plus x1..x31 clear.
// Ports: clk, rst (sync, active-high), bus (slave side of writeback bus).
module regfile_wb_arbiter
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);

    arb_state_e      state_q;
    gnt_e            last_q;
    logic [AW-1:0]   idx_q;
    logic            rf_we_q;
    logic [AW-1:0]   rf_rd_q;
    logic [XLEN-1:0] rf_wd_q;
    logic [15:0]     stall_q;
    logic [15:0]     stall_d;

    logic [1:0]      gnt;
    logic            arb_en;
    logic            stalled;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_wd;

    // A pending clear request takes the port this cycle.
    assign arb_en = (state_q == ST_ARB) && !bus.clr_req;

    rr_arb2 u_rr (
        .en_i      (arb_en),
        .a_valid_i (bus.a_valid),
        .b_valid_i (bus.b_valid),
        .last_i    (last_q),
        .gnt_o     (gnt)
    );

    assign win_rd = gnt[1] ? bus.b_rd : bus.a_rd;
    assign win_wd = gnt[1] ? bus.b_wd : bus.a_wd;

    assign stalled = (bus.a_valid && !gnt[0])
                   || (bus.b_valid && !gnt[1]);

    always_comb begin
        stall_d = stall_q;
        if (stalled && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            last_q  <= GNT_B;
            idx_q   <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
            case (state_q)
                ST_ARB: begin
                    if (bus.clr_req) begin
                        state_q <= ST_CLEAR;
                        idx_q   <= CLR_FIRST;
                        rf_we_q <= 1'b1;
                        rf_rd_q <= CLR_FIRST;
                        rf_wd_q <= '0;
                    end else if (gnt != 2'b00) begin
                        last_q  <= gnt[1] ? GNT_B : GNT_A;
                        // Writes to x0 are accepted but never reach the file.
                        rf_we_q <= (win_rd != '0);
                        if (win_rd != '0) begin
                            rf_rd_q <= win_rd;
                            rf_wd_q <= win_wd;
                        end
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (idx_q == CLR_LAST) begin
                        state_q <= ST_ARB;
                        rf_we_q <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        rf_we_q <= 1'b1;
                        rf_rd_q <= idx_q + AW'(1);
                        rf_wd_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                    rf_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_ready   = gnt[0];
    assign bus.b_ready   = gnt[1];
    assign bus.clr_busy  = (state_q == ST_CLEAR);
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors, literal checks,
// and a cycle-level reference model compared on every falling edge.
module tb_regfile_wb_arbiter;
    import rv32_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Regfile fed by the DUT write port; x0 never written.
    logic [XLEN-1:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) begin
        if (bus.rf_we && bus.rf_rd != '0) rf[bus.rf_rd] <= bus.rf_wd;
    end

    // Reference model: clearing flag + counter, last winner, pending write.
    bit              armed;
    bit              m_clr;
    int              m_idx;
    bit              m_last_b;
    int              m_stall;
    bit              e_we;
    logic [AW-1:0]   e_rd;
    logic [XLEN-1:0] e_wd;
    bit              ra;
    bit              rb;

    task automatic model_reset();
        m_clr = 0; m_idx = 0; m_last_b = 1; m_stall = 0;
        e_we = 0; e_rd = '0; e_wd = '0;
    endtask

    always @(negedge clk) begin
        if (!armed) begin
            if (rst) begin
                model_reset();
                armed = 1;
            end
        end else begin
            ra = 0;
            rb = 0;
            if (!m_clr && !bus.clr_req) begin
                if (bus.a_valid && bus.b_valid) begin
                    ra = m_last_b;
                    rb = !m_last_b;
                end else begin
                    ra = bus.a_valid;
                    rb = bus.b_valid;
                end
            end
            cmp("m_a_ready", 32'(bus.a_ready), 32'(ra));
            cmp("m_b_ready", 32'(bus.b_ready), 32'(rb));
            cmp("m_rf_we", 32'(bus.rf_we), 32'(e_we));
            if (e_we) begin
                cmp("m_rf_rd", 32'(bus.rf_rd), 32'(e_rd));
                cmp("m_rf_wd", bus.rf_wd, e_wd);
            end
            cmp("m_clr_busy", 32'(bus.clr_busy), 32'(m_clr));
            cmp("m_stall", 32'(bus.stall_cnt), 32'(m_stall));
            if (rst) begin
                model_reset();
            end else begin
                if (((bus.a_valid && !ra) || (bus.b_valid && !rb))
                    && m_stall < 65535) m_stall++;
                if (m_clr) begin
                    if (m_idx == 31) begin
                        m_clr = 0;
                        e_we = 0;
                    end else begin
                        m_idx++;
                        e_we = 1; e_rd = AW'(m_idx); e_wd = '0;
                    end
                end else if (bus.clr_req) begin
                    m_clr = 1; m_idx = 1;
                    e_we = 1; e_rd = AW'(1); e_wd = '0;
                end else if (ra) begin
                    m_last_b = 0;
                    e_we = (bus.a_rd != '0);
                    e_rd = bus.a_rd; e_wd = bus.a_wd;
                end else if (rb) begin
                    m_last_b = 1;
                    e_we = (bus.b_rd != '0);
                    e_rd = bus.b_rd; e_wd = bus.b_wd;
                end else begin
                    e_we = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; armed = 0;
        rst = 1'b1;
        bus.clr_req = 0;
        bus.a_valid = 0; bus.a_rd = '0; bus.a_wd = '0;
        bus.b_valid = 0; bus.b_rd = '0; bus.b_wd = '0;
        repeat (2) step();
        rst = 1'b0;
        cmp("rst_rf_we", 32'(bus.rf_we), 32'd0);
        cmp("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
        cmp("rst_stall", 32'(bus.stall_cnt), 32'd0);

        // Lone A write to x1.
        bus.a_valid = 1; bus.a_rd = 5'd1; bus.a_wd = 32'h11111111;
        #1 cmp("lone_a_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 0;
        cmp("lone_we", 32'(bus.rf_we), 32'd1);
        cmp("lone_rd", 32'(bus.rf_rd), 32'd1);
        cmp("lone_wd", bus.rf_wd, 32'h11111111);

        // Fresh reset, then a 4-cycle tie: A,B,A,B.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.a_valid = 1; bus.a_rd = 5'd2; bus.a_wd = 32'h22222222;
        bus.b_valid = 1; bus.b_rd = 5'd3; bus.b_wd = 32'h33333333;
        for (int k = 0; k < 4; k++) begin
            #1;
            cmp("tie_a_ready", 32'(bus.a_ready), 32'(k % 2 == 0));
            cmp("tie_b_ready", 32'(bus.b_ready), 32'(k % 2 == 1));
            step();
        end
        bus.a_valid = 0; bus.b_valid = 0;
        cmp("tie_stall", 32'(bus.stall_cnt), 32'd4);
        cmp("tie_last_rd", 32'(bus.rf_rd), 32'd3);

        // B write to x0: accepted, dropped.
        bus.b_valid = 1; bus.b_rd = 5'd0; bus.b_wd = 32'hDEADBEEF;
        #1 cmp("x0_b_ready", 32'(bus.b_ready), 32'd1);
        step();
        bus.b_valid = 0;
        cmp("x0_rf_we", 32'(bus.rf_we), 32'd0);

        // Tie after the x0 grant goes to A.
        bus.a_valid = 1; bus.a_rd = 5'd2; bus.a_wd = 32'h22222222;
        bus.b_valid = 1; bus.b_rd = 5'd3; bus.b_wd = 32'h33333333;
        #1;
        cmp("post_x0_a_ready", 32'(bus.a_ready), 32'd1);
        cmp("post_x0_b_ready", 32'(bus.b_ready), 32'd0);
        step();
        bus.a_valid = 0; bus.b_valid = 0;
        cmp("post_x0_rd", 32'(bus.rf_rd), 32'd2);
        step();
        cmp("rf_x1_pre", rf[1], 32'h11111111);
        cmp("rf_x2_pre", rf[2], 32'h22222222);
        cmp("rf_x3_pre", rf[3], 32'h33333333);

        // Clear beats a same-cycle A request.
        bus.a_valid = 1; bus.a_rd = 5'd5; bus.a_wd = 32'h55555555;
        bus.clr_req = 1;
        #1 cmp("clr_a_ready", 32'(bus.a_ready), 32'd0);
        step();
        bus.clr_req = 0;
        for (int i = 1; i <= 31; i++) begin
            cmp("clr_busy", 32'(bus.clr_busy), 32'd1);
            cmp("clr_we", 32'(bus.rf_we), 32'd1);
            cmp("clr_rd", 32'(bus.rf_rd), 32'(i));
            cmp("clr_wd", bus.rf_wd, 32'd0);
            step();
        end
        cmp("clr_done_busy", 32'(bus.clr_busy), 32'd0);
        cmp("clr_done_a_ready", 32'(bus.a_ready), 32'd1);
        for (int i = 0; i < 32; i++) cmp("rf_zero", rf[i], 32'd0);
        step();
        bus.a_valid = 0;
        cmp("after_clr_we", 32'(bus.rf_we), 32'd1);
        cmp("after_clr_rd", 32'(bus.rf_rd), 32'd5);
        cmp("after_clr_wd", bus.rf_wd, 32'h55555555);

        // Reset in the middle of a clear; a repeat clr_req is ignored.
        bus.clr_req = 1;
        step();
        bus.clr_req = 0;
        for (int i = 0; i < 9; i++) begin
            bus.clr_req = (i == 3);
            step();
        end
        bus.clr_req = 0;
        cmp("mid_clr_rd", 32'(bus.rf_rd), 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("abort_we", 32'(bus.rf_we), 32'd0);
        cmp("abort_busy", 32'(bus.clr_busy), 32'd0);
        cmp("abort_stall", 32'(bus.stall_cnt), 32'd0);
        bus.a_valid = 1; bus.a_rd = 5'd7; bus.a_wd = 32'h77777777;
        #1 cmp("abort_a_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 0;
        cmp("abort_a_rd", 32'(bus.rf_rd), 32'd7);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
